// File: rtl/cnt_mon_pkg.sv
// Shared types and defaults for the counter sequence monitor.
package cnt_mon_pkg;

    // Monitor FSM states; the encoding is visible on state_o.
    typedef enum logic [1:0] {
        MS_IDLE  = 2'b00,
        MS_SYNC  = 2'b01,
        MS_TRACK = 2'b10,
        MS_ERROR = 2'b11
    } mon_state_t;

    localparam mon_state_t ST_IDLE  = MS_IDLE;
    localparam mon_state_t ST_SYNC  = MS_SYNC;
    localparam mon_state_t ST_TRACK = MS_TRACK;
    localparam mon_state_t ST_ERROR = MS_ERROR;

    localparam int DEF_CNT_W  = 4;
    localparam int DEF_WRAP_W = 8;

endpackage

// File: rtl/sat_event_counter.sv
// Event counter that saturates at all-ones instead of rolling over.
module sat_event_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over increment; the increment is gated by a compare against all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != ALL_ONES)) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/count_seq_monitor.sv
// Checks that an upstream free-running counter advances by exactly +1 per valid
// sample; reports compare matches, wraps, a saturating wrap tally and a sticky
// sequence error. All outputs are registered with one cycle of latency.
module count_seq_monitor
    import cnt_mon_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int WRAP_W = DEF_WRAP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              arm,
    input  logic              clear_err,
    input  logic [CNT_W-1:0]  cmp_val,
    output logic              match_pulse,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              seq_err,
    output logic              locked,
    output logic [1:0]        state_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    mon_state_t       state_q, state_d;
    logic [CNT_W-1:0] prev_q, prev_d;
    logic             seq_err_q, seq_err_d;
    logic             locked_q, locked_d;
    logic             match_q, match_d;
    logic             wrap_q, wrap_d;
    logic             wrap_inc;
    logic             wrap_clr;
    logic [CNT_W-1:0] exp_cnt;

    // Expected next count: CNT_W-bit add, carry dropped so MAX+1 becomes 0.
    assign exp_cnt = prev_q + CNT_ONE;

    // Next-state and registered-output logic; arm=0 overrides clear_err and en.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        seq_err_d = seq_err_q;
        match_d   = 1'b0;
        wrap_d    = 1'b0;
        wrap_inc  = 1'b0;
        wrap_clr  = 1'b0;

        if (!arm) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                MS_IDLE: begin
                    state_d = ST_SYNC;
                end
                MS_SYNC: begin
                    // First sample only seeds prev; nothing to compare against yet.
                    if (en) begin
                        prev_d  = cnt_in;
                        state_d = ST_TRACK;
                    end
                end
                MS_TRACK: begin
                    if (en) begin
                        if (cnt_in == exp_cnt) begin
                            prev_d  = cnt_in;
                            match_d = (cnt_in == cmp_val);
                            if (prev_q == CNT_MAX) begin
                                wrap_d   = 1'b1;
                                wrap_inc = 1'b1;
                            end
                        end else begin
                            state_d   = ST_ERROR;
                            seq_err_d = 1'b1;
                        end
                    end
                end
                MS_ERROR: begin
                    // A sample coinciding with clear_err is dropped; SYNC takes the next one.
                    if (clear_err) begin
                        state_d   = ST_SYNC;
                        seq_err_d = 1'b0;
                        wrap_clr  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        locked_d = (state_d == ST_TRACK);
    end

    // State, history and output registers; reset clears everything including the sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            prev_q    <= '0;
            seq_err_q <= 1'b0;
            locked_q  <= 1'b0;
            match_q   <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            seq_err_q <= seq_err_d;
            locked_q  <= locked_d;
            match_q   <= match_d;
            wrap_q    <= wrap_d;
        end
    end

    sat_event_counter #(
        .W (WRAP_W)
    ) u_wrap_cnt (
        .clk     (clk),
        .clr_i   (reset | wrap_clr),
        .inc_i   (wrap_inc & ~reset),
        .count_o (wrap_count)
    );

    assign match_pulse = match_q;
    assign wrap_pulse  = wrap_q;
    assign seq_err     = seq_err_q;
    assign locked      = locked_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed-vector bench for count_seq_monitor.
module tb_count_seq_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] cnt_in;
    logic       arm;
    logic       clear_err;
    logic [3:0] cmp_val;
    logic       match_pulse;
    logic       wrap_pulse;
    logic [7:0] wrap_count;
    logic       seq_err;
    logic       locked;
    logic [1:0] state_o;

    int n_vec = 0;
    int n_err = 0;

    // Observed bundle: {state, locked, seq_err, match, wrap, wrap_count}
    logic [13:0] obs;
    assign obs = {state_o, locked, seq_err, match_pulse, wrap_pulse, wrap_count};

    count_seq_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .cnt_in      (cnt_in),
        .arm         (arm),
        .clear_err   (clear_err),
        .cmp_val     (cmp_val),
        .match_pulse (match_pulse),
        .wrap_pulse  (wrap_pulse),
        .wrap_count  (wrap_count),
        .seq_err     (seq_err),
        .locked      (locked),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, then land 1 time unit after the capturing edge.
    task automatic cyc(input logic r, input logic a, input logic e, input logic c,
                       input logic [3:0] cnt, input logic [3:0] cmp);
        reset = r; arm = a; en = e; clear_err = c; cnt_in = cnt; cmp_val = cmp;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [13:0] e;
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1, 4'd7, 4'd7);
        e = {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL reset: got %h want %h", obs, e); end
    endtask

    task automatic test_sync_lock();
        logic [13:0] e;
        cyc(0, 1, 1, 0, 4'd9, 4'd5);          // IDLE: sample ignored, go SYNC
        e = {2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL sync_entry: got %h want %h", obs, e); end
        cyc(0, 1, 1, 0, 4'd0, 4'd5);          // SYNC: seed prev=0
        e = {2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL lock: got %h want %h", obs, e); end
        for (int v = 1; v <= 2; v++) begin
            cyc(0, 1, 1, 0, 4'(v), 4'd5);
            n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL track_%0d: got %h want %h", v, obs, e); end
        end
    endtask

    task automatic test_match();
        logic [13:0] e;
        for (int v = 3; v <= 7; v++) begin
            cyc(0, 1, 1, 0, 4'(v), 4'd5);
            e = {2'b10, 1'b1, 1'b0, (v == 5) ? 1'b1 : 1'b0, 1'b0, 8'd0};
            n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL match_cnt%0d: got %h want %h", v, obs, e); end
        end
    endtask

    task automatic test_wrap();
        logic [13:0] e;
        for (int v = 8; v <= 15; v++) cyc(0, 1, 1, 0, 4'(v), 4'd0);
        cyc(0, 1, 1, 0, 4'd0, 4'd0);          // 15->0 with cmp_val=0: both pulses
        e = {2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1};
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL wrap_and_match: got %h want %h", obs, e); end
        cyc(0, 1, 1, 0, 4'd1, 4'd0);
        e = {2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL wrap_one_cycle: got %h want %h", obs, e); end
        // 4800 more samples starting at 2: value 0 appears 300 times.
        for (int i = 0; i < 4800; i++) cyc(0, 1, 1, 0, 4'((2 + i) & 15), 4'd9);
        e = {2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'd255};
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL wrap_saturate: got %h want %h", obs, e); end
        for (int v = 2; v <= 15; v++) cyc(0, 1, 1, 0, 4'(v), 4'd9);
        cyc(0, 1, 1, 0, 4'd0, 4'd9);
        e = {2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 8'd255};
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL wrap_hold_max: got %h want %h", obs, e); end
    endtask

    task automatic test_error();
        logic [13:0] e;
        for (int v = 1; v <= 7; v++) cyc(0, 1, 1, 0, 4'(v), 4'd9);
        cyc(0, 1, 1, 0, 4'd9, 4'd9);          // skip 7->9
        e = {2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 8'd255};
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL skip_error: got %h want %h", obs, e); end
        cyc(0, 1, 1, 0, 4'd10, 4'd9);         // en ignored in ERROR
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL error_sticky: got %h want %h", obs, e); end
        cyc(0, 1, 0, 1, 4'd0, 4'd9);
        e = {2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL clear_err: got %h want %h", obs, e); end
        cyc(0, 1, 1, 0, 4'd6, 4'd7);
        cyc(0, 1, 1, 0, 4'd7, 4'd7);
        e = {2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL resync_match: got %h want %h", obs, e); end
        cyc(0, 1, 1, 0, 4'd7, 4'd7);          // stall 7->7: no match pulse
        e = {2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL stall_error: got %h want %h", obs, e); end
        cyc(0, 1, 1, 1, 4'd8, 4'd7);          // clear with en: sample discarded
        e = {2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL clear_with_en: got %h want %h", obs, e); end
        cyc(0, 1, 1, 0, 4'd3, 4'd7);
        cyc(0, 1, 1, 0, 4'd4, 4'd7);
        e = {2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL resync_next_en: got %h want %h", obs, e); end
    endtask

    task automatic test_en_gap_and_disarm();
        logic [13:0] e;
        cyc(0, 1, 0, 0, 4'd12, 4'd12);        // en=0: garbage ignored
        e = {2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL en_low_hold: got %h want %h", obs, e); end
        cyc(0, 1, 1, 0, 4'd5, 4'd12);
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL en_resume: got %h want %h", obs, e); end
        for (int v = 6; v <= 15; v++) cyc(0, 1, 1, 0, 4'(v), 4'd12);
        for (int v = 0; v <= 15; v++) cyc(0, 1, 1, 0, 4'(v), 4'd12);
        e = {2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL pre_disarm: got %h want %h", obs, e); end
        cyc(0, 0, 1, 0, 4'd0, 4'd0);          // arm=0 on a wrap+match sample
        e = {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL disarm: got %h want %h", obs, e); end
    endtask

    task automatic test_reset_in_error();
        logic [13:0] e;
        cyc(0, 1, 1, 0, 4'd0, 4'd0);          // IDLE -> SYNC
        cyc(0, 1, 1, 0, 4'd2, 4'd0);          // seed
        cyc(0, 1, 1, 0, 4'd5, 4'd0);          // skip
        e = {2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL error_before_reset: got %h want %h", obs, e); end
        cyc(1, 1, 1, 1, 4'd3, 4'd0);
        e = {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL reset_wins: got %h want %h", obs, e); end
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; en = 1'b0; clear_err = 1'b0; cnt_in = '0; cmp_val = '0;
        test_reset();
        test_sync_lock();
        test_match();
        test_wrap();
        test_error();
        test_en_gap_and_disarm();
        test_reset_in_error();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
